mem_responder: RTL and testbench

- Target side of the CPU's byte-wide memory interface.
- Serves single-byte reads and writes from the CPU.
- The upper 16 bytes of the address space are a memory-mapped I/O window. It holds an LED register, a transmit-byte FIFO with a valid/ready output to a serial transmitter, and a status/overflow register.
- Everything outside the I/O window is backed by block RAM.

---
 rtl/robin_mem_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 51 +++++
 rtl/mem_responder.sv | 78 +++++++
 tb/tb_mem_responder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/robin_mem_pkg.sv
// robin_mem_pkg: I/O window offsets, status bit layout and status packing for mem_responder.
package robin_mem_pkg;
  localparam logic [3:0] IO_LEDS   = 4'd0;
  localparam logic [3:0] IO_TXDATA = 4'd1;
  localparam logic [3:0] IO_STATUS = 4'd2;
  localparam int ST_EMPTY  = 4;
  localparam int ST_FULL   = 5;
  localparam int ST_OVF    = 6;
  localparam int IO_WINDOW = 16;

  function automatic logic [7:0] status_byte(input logic [3:0] cnt, input logic emp,
                                             input logic ful, input logic ovf);
    logic [7:0] s;
    s = {4'd0, cnt};
    s[ST_EMPTY] = emp;
    s[ST_FULL]  = ful;
    s[ST_OVF]   = ovf;
    return s;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       drop
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [3:0]    count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    empty   = count_q == 4'd0;
    full    = count_q == DEPTH_C;
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    drop    = push & ~push_ok;
    rd_d    = rd_q + PW'(pop_ok);
    wr_d    = wr_q + PW'(push_ok);
    count_d = count_q + 4'(push_ok) - 4'(pop_ok);
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end

  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= din;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-wide CPU memory target with block RAM and a 16-byte I/O window
// (LEDs, TX FIFO, status) at the top of the address space.
module mem_responder
  import robin_mem_pkg::*;
#(
  parameter int addr_width = 9,
  parameter int fifo_depth = 8,
  parameter int io_base    = 2**addr_width - IO_WINDOW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] mem_raddr,
  input  logic [addr_width-1:0] mem_waddr,
  input  logic [7:0]            mem_data_in,
  input  logic                  mem_write,
  output logic [7:0]            mem_data_out,
  output logic                  mem_ready,
  output logic [7:0]            leds,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);
  localparam logic [addr_width-1:0] IO_B = io_base[addr_width-1:0];

  logic [7:0] ram_q [2**addr_width];
  logic [7:0] ram_rd_q, io_rd_q, io_rd_d, leds_q, leds_d;
  logic       ram_sel_q, ram_sel_d, ready_q, ready_d, ovf_q, ovf_d;
  logic       r_io, w_io, ram_we, push, drop, full, empty;
  logic [3:0] roff, woff, count;

  byte_fifo #(.DEPTH(fifo_depth)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(tx_ready), .din(mem_data_in),
    .head(tx_data), .count(count), .full(full), .empty(empty), .drop(drop)
  );

  always_comb begin
    r_io      = mem_raddr[addr_width-1:4] == IO_B[addr_width-1:4];
    w_io      = mem_waddr[addr_width-1:4] == IO_B[addr_width-1:4];
    roff      = mem_raddr[3:0];
    woff      = mem_waddr[3:0];
    ram_we    = mem_write & ~w_io;
    push      = mem_write & w_io & (woff == IO_TXDATA);
    io_rd_d   = !r_io ? 8'd0 :
                roff == IO_LEDS   ? leds_q :
                roff == IO_STATUS ? status_byte(count, empty, full, ovf_q) : 8'd0;
    ram_sel_d = ~r_io;
    leds_d    = (mem_write & w_io & (woff == IO_LEDS)) ? mem_data_in : leds_q;
    // a fresh overflow outranks a clear in the same cycle
    ovf_d     = drop ? 1'b1 :
                (mem_write & w_io & (woff == IO_STATUS) & mem_data_in[ST_OVF]) ? 1'b0 : ovf_q;
    ready_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      io_rd_q   <= '0;
      ram_sel_q <= 1'b0;
      leds_q    <= '0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      io_rd_q   <= io_rd_d;
      ram_sel_q <= ram_sel_d;
      leds_q    <= leds_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
    end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[mem_waddr] <= mem_data_in;
    ram_rd_q <= ram_q[mem_raddr];
  end

  assign mem_data_out = ram_sel_q ? ram_rd_q : io_rd_q;
  assign mem_ready    = ready_q;
  assign leds         = leds_q;
  assign tx_valid     = ~empty;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of RAM, LED, TX FIFO, status and reset behaviour.
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] mem_raddr = '0, mem_waddr = '0;
  logic [7:0] mem_data_in = '0, mem_data_out, leds, tx_data;
  logic       mem_write = 1'b0, mem_ready, tx_valid, tx_ready = 1'b0;
  int         n_cmp = 0, n_err = 0;
  logic [7:0] v;
  logic [7:0] exp_pop [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h77};

  localparam logic [8:0] A_LED = 9'h1F0, A_TX = 9'h1F1, A_ST = 9'h1F2;

  mem_responder dut (
    .clk(clk), .reset(reset), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .leds(leds), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    mem_waddr = a;
    mem_data_in = d;
    mem_write = 1'b1;
    step();
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, output logic [7:0] d);
    mem_raddr = a;
    step();
    d = mem_data_out;
  endtask

  initial begin
    #3;
    chk("rst_ready", 8'(mem_ready), 8'h00);
    chk("rst_leds", leds, 8'h00);
    chk("rst_txv", 8'(tx_valid), 8'h00);
    chk("rst_dout", mem_data_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("ready_up", 8'(mem_ready), 8'h01);

    wr(9'h040, 8'hDE);
    wr(9'h041, 8'hAD);
    wr(9'h042, 8'hBE);
    wr(9'h043, 8'hEF);
    rd(9'h040, v); chk("ram40", v, 8'hDE);
    mem_raddr = 9'h041;
    #2 chk("ram_latency", mem_data_out, 8'hDE);
    rd(9'h041, v); chk("ram41", v, 8'hAD);
    rd(9'h042, v); chk("ram42", v, 8'hBE);
    rd(9'h043, v); chk("ram43", v, 8'hEF);

    wr(A_LED, 8'h5A);
    chk("leds", leds, 8'h5A);
    rd(A_LED, v); chk("led_rd", v, 8'h5A);

    rd(A_ST, v); chk("st_empty", v, 8'h10);
    for (int i = 1; i <= 9; i++) wr(A_TX, 8'(i));
    rd(A_ST, v); chk("st_full_ovf", v, 8'h68);
    chk("tx_head", tx_data, 8'h01);
    chk("txv_full", 8'(tx_valid), 8'h01);
    rd(A_TX, v); chk("tx_rd0", v, 8'h00);
    wr(A_ST, 8'h40);
    rd(A_ST, v); chk("ovf_clr", v, 8'h28);

    mem_waddr = A_TX;
    mem_data_in = 8'h77;
    mem_write = 1'b1;
    tx_ready = 1'b1;
    step();
    mem_write = 1'b0;
    tx_ready = 1'b0;
    rd(A_ST, v); chk("full_pushpop", v, 8'h28);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pop%0d", i), tx_data, exp_pop[i]);
      step();
    end
    tx_ready = 1'b0;
    chk("drained", 8'(tx_valid), 8'h00);

    wr(9'h080, 8'h11);
    mem_raddr = 9'h080;
    wr(9'h080, 8'h22);
    chk("rbw_old", mem_data_out, 8'h11);
    step();
    chk("rbw_new", mem_data_out, 8'h22);

    wr(A_TX, 8'hA1);
    wr(A_TX, 8'hA2);
    wr(A_TX, 8'hA3);
    rd(A_ST, v); chk("st_cnt3", v, 8'h03);
    rd(9'h080, v);
    chk("pre_rst_txv", 8'(tx_valid), 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("arst_txv", 8'(tx_valid), 8'h00);
    chk("arst_leds", leds, 8'h00);
    chk("arst_dout", mem_data_out, 8'h00);
    chk("arst_ready", 8'(mem_ready), 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rel_ready_lo", 8'(mem_ready), 8'h00);
    step();
    chk("rel_ready_hi", 8'(mem_ready), 8'h01);
    rd(A_ST, v); chk("st_after_rst", v, 8'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
